// File: rtl/dm_pkg.sv
// Shared encodings for the wait-state data memory: access widths, FSM states and
// the alignment rule used by both the lane aligner and any future consumers.
package dm_pkg;

   typedef enum logic [1:0] {
      DM_OP_WORD = 2'b00,
      DM_OP_HALF = 2'b01,
      DM_OP_BYTE = 2'b10,
      DM_OP_RSVD = 2'b11
   } dm_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } dm_state_e;

   // Wide enough for LATENCY-1 with LATENCY up to 15
   localparam int unsigned DM_CNT_W = 4;

   function automatic logic dm_misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
      logic mis;
      case (dm_op_e'(op))
         DM_OP_WORD: mis = (addr_lo != 2'b00);
         DM_OP_HALF: mis = addr_lo[0];
         DM_OP_BYTE: mis = 1'b0;
         default:    mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: merges store data into the old word and extracts /
// extends load data from it; both are suppressed when the access is misaligned.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic        sign_ext,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] merged,
   output logic [31:0] load_data,
   output logic        misaligned
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   always_comb begin
      misaligned = dm_misaligned(op, addr_lo);
      merged     = old_word;
      load_data  = '0;
      half_sel   = '0;
      byte_sel   = '0;
      case (dm_op_e'(op))
         DM_OP_WORD: begin
            merged    = wdata;
            load_data = old_word;
         end
         DM_OP_HALF: begin
            if (addr_lo[1]) begin
               merged[31:16] = wdata[15:0];
               half_sel      = old_word[31:16];
            end else begin
               merged[15:0] = wdata[15:0];
               half_sel     = old_word[15:0];
            end
            load_data = {{16{half_sel[15] & sign_ext}}, half_sel};
         end
         DM_OP_BYTE: begin
            merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            byte_sel  = old_word[{addr_lo, 3'b000} +: 8];
            load_data = {{24{byte_sel[7] & sign_ext}}, byte_sel};
         end
         default: ;
      endcase
      // Errors leave memory untouched and return zero data
      if (misaligned) begin
         merged    = old_word;
         load_data = '0;
      end
   end

endmodule

// File: rtl/dm_wait_mem.sv
// MEM-stage data memory with a fixed access latency behind a valid/ready request and
// a one-cycle response strobe. Define DM_TRACE_EN to print each committed store.
module dm_wait_mem
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_op,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [DM_CNT_W-1:0] CNT_INIT = DM_CNT_W'(LATENCY - 1);

   dm_state_e state, state_next;
   logic [DM_CNT_W-1:0] cnt;
   logic accept, commit;

   logic        lat_we;
   logic [1:0]  lat_op;
   logic        lat_signed;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] lat_pc;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] lat_idx;
   logic [31:0]       old_word, merged, load_data;
   logic              misaligned;

   assign lat_idx  = lat_addr[ADDR_W+1:2];
   assign old_word = mem[lat_idx];
   assign busy     = ~req_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept     = 1'b1;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               commit     = 1'b1;
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                              cnt <= '0;
      else if (accept)                        cnt <= CNT_INIT;
      else if (state == ST_WAIT && cnt != '0) cnt <= cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lat_we     <= 1'b0;
         lat_op     <= '0;
         lat_signed <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_pc     <= '0;
      end else if (accept) begin
         lat_we     <= req_we;
         lat_op     <= req_op;
         lat_signed <= req_signed;
         lat_addr   <= req_addr;
         lat_wdata  <= req_wdata;
         lat_pc     <= req_pc;
      end
   end

   dm_lane_align u_align (
      .op         (lat_op),
      .addr_lo    (lat_addr[1:0]),
      .sign_ext   (lat_signed),
      .old_word   (old_word),
      .wdata      (lat_wdata),
      .merged     (merged),
      .load_data  (load_data),
      .misaligned (misaligned)
   );

   // Response registers change only at commit, so they hold between accesses
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (commit) begin
         resp_rdata <= (lat_we || misaligned) ? '0 : load_data;
         resp_err   <= misaligned;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
      end else if (commit && lat_we && !misaligned) begin
         mem[lat_idx] <= merged;
`ifdef DM_TRACE_EN
         $display("%d@%h: *%h <= %h", $time, lat_pc, {lat_addr[31:2], 2'b00}, merged);
`endif
      end
   end

`ifndef DM_TRACE_EN
   logic unused_bits;
   assign unused_bits = ^{lat_addr[31:ADDR_W+2], lat_pc};
`endif

endmodule

// File: tb/tb_dm_wait_mem.sv
// Scoreboard bench: two memories (12-bit/latency 2 and 4-bit/latency 1) share one
// request stream; a reference model predicts each response and its arrival cycle.
module tb_dm_wait_mem;

   localparam int unsigned AW0 = 12, LAT0 = 2;
   localparam int unsigned AW1 = 4,  LAT1 = 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        valid = 1'b0, we = 1'b0, sgn = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] addr = '0, wdata = '0, pc = '0;

   logic [1:0]        rdy, rv, bsy, er;
   logic [1:0][31:0]  rd;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   bit b2b = 1'b0;

   dm_wait_mem #(.ADDR_W(AW0), .LATENCY(LAT0)) u0 (
      .clk(clk), .reset(reset), .req_valid(valid), .req_ready(rdy[0]), .req_we(we),
      .req_op(op), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata), .req_pc(pc),
      .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0]), .busy(bsy[0]));

   dm_wait_mem #(.ADDR_W(AW1), .LATENCY(LAT1)) u1 (
      .clk(clk), .reset(reset), .req_valid(valid), .req_ready(rdy[1]), .req_we(we),
      .req_op(op), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata), .req_pc(pc),
      .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1]), .busy(bsy[1]));

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] acc;
      logic [31:0] due;
   } exp_t;

   exp_t        q [2][$];
   logic [31:0] mm [2][4096];
   logic [31:0] last_rd [2];
   logic        last_er [2];
   int unsigned prev_acc [2];
   bit          have_prev [2];

   function automatic int unsigned lat_of(input int d);
      return (d == 0) ? LAT0 : LAT1;
   endfunction

   function automatic int unsigned words_of(input int d);
      return (d == 0) ? (1 << AW0) : (1 << AW1);
   endfunction

   // Reference behaviour from size/offset arithmetic
   function automatic void model(input logic w, input logic [1:0] o, input logic s,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] old,
                                 output logic [31:0] nw, output logic [31:0] rdv, output logic e);
      int unsigned nb, bits, sh;
      logic [31:0] mask, v;
      nb   = (o == 2'd0) ? 4 : (o == 2'd1) ? 2 : 1;
      bits = nb * 8;
      sh   = 8 * int'(a[1:0]);
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
      e    = (o == 2'd3) || (a % nb != 0);
      nw   = old;
      rdv  = '0;
      if (!e) begin
         if (w) nw = (old & ~(mask << sh)) | ((wd & mask) << sh);
         else begin
            v = (old >> sh) & mask;
            if (s && nb < 4 && v[bits-1]) v = v | ~mask;
            rdv = v;
         end
      end
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[u%0d] @cyc %0d: got %h required %h", nm, d, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            q[d].delete();
            for (int i = 0; i < 4096; i++) mm[d][i] = '0;
            last_rd[d]   = '0;
            last_er[d]   = 1'b0;
            have_prev[d] = 1'b0;
         end else begin
            logic exp_busy;
            exp_busy = (q[d].size() != 0) && (q[d][0].acc <= cyc);
            chk("busy", d, 32'(bsy[d]), 32'(exp_busy));
            chk("ready", d, 32'(rdy[d]), 32'(!exp_busy));
            if (rv[d]) begin
               if (q[d].size() == 0 || q[d][0].acc > cyc) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_resp[u%0d] @cyc %0d: got resp_valid=1 required 0", d, cyc);
               end else begin
                  exp_t e;
                  e = q[d].pop_front();
                  chk("resp_cycle", d, cyc, e.due);
                  chk("rdata", d, rd[d], e.rdata);
                  chk("err", d, 32'(er[d]), 32'(e.err));
                  last_rd[d] = e.rdata;
                  last_er[d] = e.err;
               end
            end else begin
               chk("hold_rdata", d, rd[d], last_rd[d]);
               chk("hold_err", d, 32'(er[d]), 32'(last_er[d]));
               if (q[d].size() != 0 && cyc > q[d][0].due) begin
                  total++;
                  bad++;
                  $display("FAIL missing_resp[u%0d] @cyc %0d: got no resp_valid, required at cyc %0d",
                           d, cyc, q[d][0].due);
                  void'(q[d].pop_front());
               end
            end
            if (!b2b) have_prev[d] = 1'b0;
            if (valid && rdy[d]) begin
               int unsigned idx;
               logic [31:0] nw, rdv;
               logic e;
               idx = (addr >> 2) % words_of(d);
               model(we, op, sgn, addr, wdata, mm[d][idx], nw, rdv, e);
               if (we && !e) mm[d][idx] = nw;
               q[d].push_back('{rdata: rdv, err: e, acc: cyc + 1, due: cyc + 1 + lat_of(d)});
               if (b2b && have_prev[d]) chk("accept_interval", d, cyc + 1 - prev_acc[d], lat_of(d) + 2);
               prev_acc[d]  = cyc + 1;
               have_prev[d] = 1'b1;
            end
         end
      end
   end

   task automatic wait_idle();
      int unsigned n = 0;
      while (!(rdy[0] && rdy[1])) begin
         @(posedge clk); #1;
         n++;
         if (n > 60) begin
            $display("FAIL idle_timeout: req_ready low for %0d cycles, required high", n);
            $fatal(1, "request interface stuck");
         end
      end
   endtask

   task automatic issue(input logic w, input logic [1:0] o, input logic s,
                        input logic [31:0] a, input logic [31:0] d);
      wait_idle();
      we = w; op = o; sgn = s; addr = a; wdata = d; pc = $urandom;
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      valid = 1'b0;
      @(posedge clk); #1;

      issue(1, 2'd0, 0, 32'h10, 32'h1234_5678);
      issue(0, 2'd0, 0, 32'h10, 32'h0);
      issue(1, 2'd2, 0, 32'h11, 32'hAB);
      issue(0, 2'd2, 1, 32'h11, 32'h0);
      issue(0, 2'd2, 0, 32'h11, 32'h0);
      issue(0, 2'd0, 0, 32'h10, 32'h0);
      issue(1, 2'd1, 0, 32'h12, 32'h8001);
      issue(0, 2'd1, 1, 32'h12, 32'h0);
      issue(0, 2'd1, 0, 32'h12, 32'h0);
      issue(0, 2'd0, 0, 32'h10, 32'h0);
      issue(1, 2'd0, 0, 32'h13, 32'hFFFF_FFFF);
      issue(0, 2'd1, 1, 32'h11, 32'h0);
      issue(1, 2'd3, 0, 32'h10, 32'h5555_5555);
      issue(0, 2'd0, 0, 32'h10, 32'h0);

      wait_idle();
      b2b = 1'b1;
      valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         we = 1'($urandom); op = 2'($urandom); sgn = 1'($urandom);
         addr = 32'($urandom_range(0, 63)); wdata = $urandom; pc = $urandom;
         @(posedge clk); #1;
      end
      valid = 1'b0;
      b2b = 1'b0;

      issue(1, 2'd0, 0, 32'h20, 32'hDEAD);
      pulse_reset();
      issue(0, 2'd0, 0, 32'h20, 32'h0);

      issue(1, 2'd0, 0, 32'h40, 32'hCAFE_F00D);
      issue(0, 2'd0, 0, 32'h00, 32'h0);
      issue(0, 2'd0, 0, 32'h40, 32'h0);

      for (int i = 0; i < 200; i++) begin
         issue(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)), $urandom);
         if ($urandom_range(0, 30) == 0) pulse_reset();
      end

      wait_idle();
      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
